// File: rtl/arb_pkg.sv
// Shared types and helpers for the LRU matrix arbiter.
// Grant index encoding is kept here so other blocks can reuse it.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  localparam int unsigned OH_MAX = 32;

  // OR-reduction encoder; assumes at most one bit set.
  function automatic logic [4:0] onehot2idx(
    input logic [OH_MAX-1:0] oh
  );
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lru_prio_matrix.sv
// NxN least-recently-granted priority matrix.
// pri_q[i][j]=1 means requester i beats requester j.
module lru_prio_matrix
  import arb_pkg::*;
#(
  parameter int NO_REQ    = 4,
  parameter int IDX_WIDTH = $clog2(NO_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 upd_en_i,
  input  logic [IDX_WIDTH-1:0] upd_idx_i,
  input  logic [NO_REQ-1:0]    req_i,
  output logic [NO_REQ-1:0]    win_o
);

  logic [NO_REQ-1:0][NO_REQ-1:0] pri_q;
  logic [NO_REQ-1:0][NO_REQ-1:0] pri_d;

  always_comb begin
    pri_d = pri_q;
    if (upd_en_i) begin
      for (int j = 0; j < NO_REQ; j++) begin
        pri_d[upd_idx_i][j] = 1'b0;
        pri_d[j][upd_idx_i] = (IDX_WIDTH'(j) != upd_idx_i);
      end
    end
  end

  always_comb begin
    win_o = req_i;
    for (int i = 0; i < NO_REQ; i++) begin
      for (int j = 0; j < NO_REQ; j++) begin
        if (i != j && req_i[j] && !pri_q[i][j]) begin
          win_o[i] = 1'b0;
        end
      end
    end
  end

  // Reset order: lower index has higher priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NO_REQ; i++) begin
        for (int j = 0; j < NO_REQ; j++) begin
          pri_q[i][j] <= (i < j);
        end
      end
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/lru_matrix_arbiter.sv
// Packet-holding arbiter with least-recently-granted priority.
// Grant is kept until last beat, abort, or beat-limit release.
module lru_matrix_arbiter
  import arb_pkg::*;
#(
  parameter int NO_REQ    = 4,
  parameter int IDX_WIDTH = $clog2(NO_REQ),
  parameter int MAX_BEATS = 16,
  parameter int CNT_WIDTH = $clog2(MAX_BEATS+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NO_REQ-1:0]    req,
  input  logic [NO_REQ-1:0]    req_last,
  input  logic                 beat_ack,
  output logic [NO_REQ-1:0]    gnt,
  output logic [IDX_WIDTH-1:0] gnt_idx,
  output logic                 busy,
  output logic                 timeout_err
);

  arb_state_e           state_q, state_d;
  logic [NO_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [NO_REQ-1:0]    win;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 upd_en;
  logic                 rel_last;
  logic                 rel_abort;
  logic                 rel_tmo;

  lru_prio_matrix #(
    .NO_REQ    (NO_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_mat (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_en_i  (upd_en),
    .upd_idx_i (win_idx),
    .req_i     (req),
    .win_o     (win)
  );

  assign win_idx = IDX_WIDTH'(onehot2idx(OH_MAX'(win)));

  assign rel_last  = beat_ack & req_last[idx_q];
  assign rel_abort = ~req[idx_q];
  assign rel_tmo   = beat_ack & ~req_last[idx_q]
                   & (cnt_q == CNT_WIDTH'(MAX_BEATS-1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    upd_en  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d = ARB_BUSY;
          gnt_d   = win;
          idx_d   = win_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
          upd_en  = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (rel_last | rel_abort | rel_tmo) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          // A genuine last beat at the limit is not an error.
          terr_d  = rel_tmo;
        end else if (beat_ack) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_idx     = idx_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_lru_matrix_arbiter.sv
// Directed plus random bench for lru_matrix_arbiter.
// Reference keeps an LRU queue and packet-level protocol state.
module tb_lru_matrix_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req_last;
  logic       beat_ack;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       timeout_err;

  always #5 clk = ~clk;

  lru_matrix_arbiter #(
    .NO_REQ    (N),
    .MAX_BEATS (MB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_last    (req_last),
    .beat_ack    (beat_ack),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  bit   m_busy;
  int   m_own;
  int   m_cnt;
  bit   m_terr;
  int   lru[$];
  int   waits[N];
  logic [3:0] prev_gnt;
  logic       prev_busy;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0;
    m_own  = 0;
    m_cnt  = 0;
    m_terr = 1'b0;
    lru    = {0, 1, 2, 3};
    for (int i = 0; i < N; i++) waits[i] = 0;
  endfunction

  task automatic model_step();
    int  w;
    bit  a, b, c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) if (!req[i]) waits[i] = 0;
    if (!m_busy) begin
      m_terr = 1'b0;
      if (req != 4'b0) begin
        w = -1;
        for (int k = 0; k < lru.size(); k++) begin
          if (req[lru[k]]) begin
            w = lru[k];
            lru.delete(k);
            lru.push_back(w);
            break;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (i == w) waits[i] = 0;
          else if (req[i]) waits[i]++;
        end
        m_busy = 1'b1;
        m_own  = w;
        m_cnt  = 0;
      end
    end else begin
      a = beat_ack && req_last[m_own];
      b = !req[m_own];
      c = beat_ack && !req_last[m_own] && (m_cnt == MB - 1);
      m_terr = c;
      if (a || b || c) m_busy = 1'b0;
      else if (beat_ack) m_cnt++;
    end
  endtask

  task automatic cycle();
    logic [31:0] exp_gnt;
    bit anti;
    int worst;
    model_step();
    @(posedge clk);
    #1;
    exp_gnt = m_busy ? (32'd1 << m_own) : 32'd0;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("gnt", 32'(gnt), exp_gnt);
    if (m_busy) chk("gnt_idx", 32'(gnt_idx), 32'(m_own));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (prev_busy && busy) chk("stable", 32'(gnt), 32'(prev_gnt));
    anti = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i == j && dut.u_mat.pri_q[i][j]) anti = 1'b0;
        if (i != j && dut.u_mat.pri_q[i][j] == dut.u_mat.pri_q[j][i])
          anti = 1'b0;
      end
    end
    chk("antisym", 32'(anti), 32'd1);
    worst = 0;
    for (int i = 0; i < N; i++) if (waits[i] > worst) worst = waits[i];
    chk("starve", 32'(worst <= N - 1), 32'd1);
    prev_gnt  = gnt;
    prev_busy = busy;
  endtask

  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [3:0] lst, input logic ak);
    rst_n    = r;
    req      = rq;
    req_last = lst;
    beat_ack = ak;
    cycle();
  endtask

  task automatic do_reset();
    step(1'b0, 4'b0, 4'b0, 1'b0);
    step(1'b0, 4'b0, 4'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] lst;
    model_reset();
    prev_gnt  = '0;
    prev_busy = 1'b0;
    rst_n = 1'b0; req = '0; req_last = '0; beat_ack = 1'b0;

    do_reset();
    chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);

    // 1: single-beat packets, all requesting
    step(1'b1, 4'b1111, 4'b1111, 1'b1);
    chk("t1_first", 32'(gnt), 32'h1);
    for (int k = 0; k < 10; k++) step(1'b1, 4'b1111, 4'b1111, 1'b1);

    // 2: three-beat packets from requesters 1 and 2
    do_reset();
    for (int k = 0; k < 14; k++) begin
      lst = (m_busy && m_cnt == 2) ? 4'b1111 : 4'b0000;
      step(1'b1, 4'b0110, lst, 1'b1);
    end

    // 3: last held without ack
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 4'b0010, 4'b0010, 1'b0);
    chk("t3_held", 32'(busy), 32'd1);
    step(1'b1, 4'b0010, 4'b0010, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // 4: beat limit, then last beat exactly at the limit
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 4'b1000, 4'b0000, 1'b1);
    for (int k = 0; k < 6; k++) begin
      lst = (m_busy && m_cnt == MB - 1) ? 4'b1000 : 4'b0000;
      step(1'b1, 4'b1000, lst, 1'b1);
    end
    step(1'b1, 4'b0000, 4'b0000, 1'b0);

    // 5: abort by requester 0
    do_reset();
    step(1'b1, 4'b0001, 4'b0000, 1'b1);
    step(1'b1, 4'b0001, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b1111, 4'b1111, 1'b1);

    // 6: reset mid-packet
    do_reset();
    step(1'b1, 4'b0100, 4'b0000, 1'b0);
    step(1'b1, 4'b0100, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 4'b0000, 1'b0);
    step(1'b1, 4'b1010, 4'b0000, 1'b0);
    chk("t6_gnt", 32'(gnt), 32'h2);
    step(1'b1, 4'b1010, 4'b1010, 1'b1);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      step(1'b1 ^ ($urandom_range(0, 99) == 0),
           4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
